// File: rtl/hdr_seq.sv
`default_nettype none
// ============================================================================
// Module      : hdr_seq
// Description : Header word sequencer. Snapshots counter fields on start and
//               emits SYNC, fields, zero pads and an optional XOR checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module hdr_seq #(
    parameter int          DATA_W     = 32,
    parameter int          NUM_FIELDS = 2,
    parameter int          PAD_WORDS  = 1,
    parameter logic [31:0] SYNC_WORD  = 32'hA5A5_5A5A,
    parameter int          CSUM_EN    = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_FIELDS*DATA_W-1:0] fields_in,
    input  logic                         start,
    input  logic                         rd_en,
    output logic [DATA_W-1:0]            data_out,
    output logic                         data_valid,
    output logic                         last,
    output logic                         busy,
    output logic                         start_drop
);

    localparam int C_MAX_CNT = (NUM_FIELDS > PAD_WORDS) ? NUM_FIELDS : PAD_WORDS;
    localparam int IDX_W     = (C_MAX_CNT > 2) ? $clog2(C_MAX_CNT) : 1;
    localparam logic [IDX_W-1:0]  C_FLD_LAST = IDX_W'(NUM_FIELDS - 1);
    localparam logic [IDX_W-1:0]  C_PAD_LAST = IDX_W'((PAD_WORDS > 0) ? PAD_WORDS - 1 : 0);
    localparam logic [DATA_W-1:0] C_SYNC     = DATA_W'(SYNC_WORD);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SYNC  = 3'd1,
        S_FIELD = 3'd2,
        S_PAD   = 3'd3,
        S_CSUM  = 3'd4
    } state_t;

    state_t                       r_state, w_state_nxt;
    logic [IDX_W-1:0]             r_idx, w_idx_nxt;
    logic [NUM_FIELDS*DATA_W-1:0] r_snap, w_snap_nxt;
    logic [DATA_W-1:0]            r_csum, w_csum_nxt;
    logic [DATA_W-1:0]            r_data, w_data_nxt;
    logic                         r_valid, r_last, r_drop;
    logic                         w_last_nxt, w_drop_nxt;
    logic                         w_advance, w_accept;
    logic [DATA_W-1:0]            w_xor;

    always_comb begin
        w_xor = C_SYNC;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            w_xor = w_xor ^ fields_in[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        w_advance   = r_valid & rd_en;
        // A start is taken from idle, or on the very edge the final word leaves.
        w_accept    = start & ((r_state == S_IDLE) | (w_advance & r_last));
        w_drop_nxt  = start & ~w_accept;
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_snap_nxt  = w_accept ? fields_in : r_snap;
        w_csum_nxt  = w_accept ? w_xor : r_csum;

        if (w_accept) begin
            w_state_nxt = S_SYNC;
            w_idx_nxt   = '0;
        end else if (w_advance) begin
            if (r_last) begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end else begin
                case (r_state)
                    S_SYNC: begin
                        w_state_nxt = S_FIELD;
                        w_idx_nxt   = '0;
                    end
                    S_FIELD: begin
                        if (r_idx == C_FLD_LAST) begin
                            w_idx_nxt   = '0;
                            w_state_nxt = (PAD_WORDS > 0) ? S_PAD : S_CSUM;
                        end else begin
                            w_idx_nxt = r_idx + 1'b1;
                        end
                    end
                    S_PAD: begin
                        if (r_idx == C_PAD_LAST) begin
                            w_idx_nxt   = '0;
                            w_state_nxt = S_CSUM;
                        end else begin
                            w_idx_nxt = r_idx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        // Output word is registered, so it is selected from the next state.
        w_data_nxt = '0;
        w_last_nxt = 1'b0;
        case (w_state_nxt)
            S_SYNC: w_data_nxt = C_SYNC;
            S_FIELD: begin
                for (int i = 0; i < NUM_FIELDS; i++) begin
                    if (w_idx_nxt == IDX_W'(i)) begin
                        w_data_nxt = w_snap_nxt[i*DATA_W +: DATA_W];
                    end
                end
                w_last_nxt = (w_idx_nxt == C_FLD_LAST) && (PAD_WORDS == 0) && (CSUM_EN == 0);
            end
            S_PAD: w_last_nxt = (w_idx_nxt == C_PAD_LAST) && (CSUM_EN == 0);
            S_CSUM: begin
                w_data_nxt = w_csum_nxt;
                w_last_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_snap  <= '0;
            r_csum  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_snap  <= w_snap_nxt;
            r_csum  <= w_csum_nxt;
            r_data  <= w_data_nxt;
            r_valid <= (w_state_nxt != S_IDLE);
            r_last  <= w_last_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign last       = r_last;
    assign busy       = (r_state != S_IDLE);
    assign start_drop = r_drop;

endmodule
`default_nettype wire
